boundary_scroll_buf: RTL and testbench

BOUNDARY_SCROLL_BUF -- requirements
Module: boundary_scroll_buf

---
 rtl/boundary_scroll_buf.sv | 193 +++++++++++++++++++
 tb/tb_boundary_scroll_buf.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_scroll_buf.sv
// boundary_scroll_buf: 480-row x 40-bit scrolling boundary store for the VGA path.
// A circular head pointer turns each scroll into a single RAM write; a zero-fill
// sequence runs after reset or a clear pulse.
// Build option: define BOUNDARY_VBLANK_SYNC_EN to defer each scroll write until
// vblank (vcount >= 480); when it is undefined, a pending scroll is written on
// the next cycle and vcount is ignored.
module boundary_scroll_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift,
  input  logic [39:0] datain,
  input  logic [9:0]  vcount,
  input  logic [8:0]  readaddress,
  output logic [39:0] dataout,
  output logic        busy,
  output logic        shift_overrun
);

  localparam int unsigned DW   = 40;
  localparam int unsigned AW   = 9;
  localparam int unsigned SW   = AW + 1;
  localparam int unsigned VW   = 10;
  localparam int unsigned ROWS = 480;

  localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_PEND  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [DW-1:0]   mem [ROWS];

  logic [AW-1:0]   head;
  logic [AW-1:0]   head_dec;
  logic [AW-1:0]   clr_addr;
  logic            shift_q;
  logic            shift_edge;
  logic            req_held;
  logic [DW-1:0]   req_word;
  logic            vblank;

  logic [SW-1:0]   rd_sum;
  logic            rd_in_range;
  logic [AW-1:0]   rd_addr;

  logic            mem_we_c;
  logic [AW-1:0]   mem_waddr_c;
  logic [DW-1:0]   mem_wdata_c;
  logic            capture_c;
  logic            overrun_set_c;
  logic            head_step_c;

`ifdef BOUNDARY_VBLANK_SYNC_EN
  assign vblank = (vcount >= VW'(ROWS));
`else
  logic unused_vcount;
  assign unused_vcount = ^vcount;
  assign vblank        = 1'b1;
`endif

  // One registered copy of shift; a rising edge is one scroll request
  assign shift_edge = shift & ~shift_q;

  // New head after a scroll, wrapping 0 -> 479
  assign head_dec = (head == '0) ? LAST_ROW : head - AW'(1);

  // Logical row to physical address: head + row, folded back into 0..479
  assign rd_in_range = (readaddress < AW'(ROWS));
  assign rd_sum      = SW'(head) + SW'(readaddress);
  always_comb begin
    rd_addr = '0;
    if (rd_in_range) begin
      if (rd_sum >= SW'(ROWS)) rd_addr = AW'(rd_sum - SW'(ROWS));
      else                     rd_addr = AW'(rd_sum);
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_CLEAR;
    else       state <= state_next;
  end

  // Next-state logic; clear restarts the zero fill from any state
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_CLEAR;
    end else begin
      case (state)
        S_CLEAR: if (clr_addr == LAST_ROW) state_next = (req_held || shift_edge) ? S_PEND : S_IDLE;
        S_IDLE:  if (shift_edge) state_next = S_PEND;
        S_PEND:  if (vblank) state_next = S_WRITE;
        S_WRITE: state_next = S_IDLE;
        default: state_next = S_CLEAR;
      endcase
    end
  end

  // Control strobes: RAM write port, request capture/drop, head step
  always_comb begin
    mem_we_c      = 1'b0;
    mem_waddr_c   = '0;
    mem_wdata_c   = '0;
    capture_c     = 1'b0;
    overrun_set_c = 1'b0;
    head_step_c   = 1'b0;
    if (!clear) begin
      capture_c     = shift_edge & ~req_held;
      overrun_set_c = shift_edge &  req_held;
      case (state)
        S_CLEAR: begin
          mem_we_c    = 1'b1;
          mem_waddr_c = clr_addr;
        end
        S_WRITE: begin
          mem_we_c    = 1'b1;
          mem_waddr_c = head_dec;
          mem_wdata_c = req_word;
          head_step_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Edge-detect register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shift_q <= 1'b0;
    else       shift_q <= shift;
  end

  // Zero-fill address, one row per CLEAR cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  clr_addr <= '0;
    else if (clear)             clr_addr <= '0;
    else if (state == S_CLEAR)  clr_addr <= (clr_addr == LAST_ROW) ? '0 : clr_addr + AW'(1);
  end

  // Head pointer moves up one row per committed scroll
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            head <= '0;
    else if (clear)       head <= '0;
    else if (head_step_c) head <= head_dec;
  end

  // One-deep request holder
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_held <= 1'b0;
      req_word <= '0;
    end else if (clear) begin
      req_held <= 1'b0;
    end else if (head_step_c) begin
      req_held <= 1'b0;
    end else if (capture_c) begin
      req_held <= 1'b1;
      req_word <= datain;
    end
  end

  // Sticky dropped-request flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              shift_overrun <= 1'b0;
    else if (overrun_set_c) shift_overrun <= 1'b1;
  end

  // busy mirrors the CLEAR state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= 1'b1;
    else       busy <= (state_next == S_CLEAR);
  end

  // RAM write port
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // Registered read port; old data on a same-address write; zero while filling
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       dataout <= '0;
    else if (clear || state == S_CLEAR || !rd_in_range) dataout <= '0;
    else                                             dataout <= mem[rd_addr];
  end

endmodule

// File: tb/tb_boundary_scroll_buf.sv
// Bench for boundary_scroll_buf: directed sequences, a read-vector table and a
// randomized phase, all against a logical-row reference model.
module tb_boundary_scroll_buf;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        shift;
  logic [39:0] datain;
  logic [9:0]  vcount;
  logic [8:0]  readaddress;
  logic [39:0] dataout;
  logic        busy;
  logic        shift_overrun;

  boundary_scroll_buf dut (
    .clk          (clk),
    .reset        (reset),
    .clear        (clear),
    .shift        (shift),
    .datain       (datain),
    .vcount       (vcount),
    .readaddress  (readaddress),
    .dataout      (dataout),
    .busy         (busy),
    .shift_overrun(shift_overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: screen as an array of logical rows (row 0 = top)
  logic [39:0] m_rows [480];
  int          m_fill;
  bit          m_held;
  logic [39:0] m_word;
  int          m_stage;   // 0 none, 1 waiting for vblank, 2 committing
  bit          m_ovr;
  bit          m_prev;
  logic [39:0] exp_dout;
  bit          exp_busy;

  typedef struct {
    logic [8:0]  ra;
    logic [39:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill   = 480;
    m_held   = 0;
    m_stage  = 0;
    m_ovr    = 0;
    m_prev   = 0;
    exp_dout = '0;
    exp_busy = 1;
  endtask

  task automatic model_step();
    bit edge_s;
    bit vb;
`ifdef BOUNDARY_VBLANK_SYNC_EN
    vb = (vcount >= 10'd480);
`else
    vb = 1'b1;
`endif
    edge_s = shift && !m_prev;
    m_prev = shift;
    exp_dout = (clear || m_fill > 0 || readaddress >= 9'd480) ? 40'h0 : m_rows[readaddress];
    if (clear) begin
      m_fill  = 480;
      m_held  = 0;
      m_stage = 0;
    end else if (m_fill > 0) begin
      if (edge_s) begin
        if (m_held) m_ovr = 1;
        else begin m_held = 1; m_word = datain; end
      end
      m_fill--;
      if (m_fill == 0) begin
        for (int r = 0; r < 480; r++) m_rows[r] = '0;
        if (m_held) m_stage = 1;
      end
    end else begin
      case (m_stage)
        0: if (edge_s) begin m_held = 1; m_word = datain; m_stage = 1; end
        1: begin
          if (edge_s) m_ovr = 1;
          if (vb) m_stage = 2;
        end
        default: begin
          if (edge_s) m_ovr = 1;
          for (int r = 479; r > 0; r--) m_rows[r] = m_rows[r-1];
          m_rows[0] = m_word;
          m_held  = 0;
          m_stage = 0;
        end
      endcase
    end
    exp_busy = (m_fill > 0);
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    @(negedge clk);
    chk("model_dataout", dataout, exp_dout);
    chk("model_busy", busy, exp_busy);
    chk("model_overrun", shift_overrun, m_ovr);
  endtask

  task automatic read_row(input logic [8:0] ra, output logic [39:0] d);
    readaddress = ra;
    cycle();
    d = dataout;
  endtask

  task automatic do_shift(input logic [39:0] w);
    datain = w;
    shift  = 1'b1;
    cycle();
    shift  = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 1000) begin
      n++;
      cycle();
    end
    chk(name, n, 480);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [39:0] d;
    logic [39:0] exp_a;
    logic [39:0] exp_b;
    logic [39:0] w_a;
    logic [39:0] w_b;

    tbl[0] = '{9'd0,   40'd480};
    tbl[1] = '{9'd1,   40'd479};
    tbl[2] = '{9'd2,   40'd478};
    tbl[3] = '{9'd100, 40'd380};
    tbl[4] = '{9'd240, 40'd240};
    tbl[5] = '{9'd478, 40'd2};
    tbl[6] = '{9'd479, 40'd1};
    tbl[7] = '{9'd480, 40'd0};
    tbl[8] = '{9'd511, 40'd0};
    tbl[9] = '{9'd0,   40'd480};

    for (int r = 0; r < 480; r++) m_rows[r] = '0;
    m_word      = '0;
    reset       = 1'b1;
    clear       = 1'b0;
    shift       = 1'b0;
    datain      = '0;
    vcount      = 10'd0;
    readaddress = 9'd0;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state and zero-fill length
    chk("reset_busy", busy, 1'b1);
    chk("reset_dataout", dataout, 40'h0);
    chk("reset_overrun", shift_overrun, 1'b0);
    count_busy("busy_len_after_reset");
    read_row(9'd0, d);   chk("zero_row0", d, 40'h0);
    read_row(9'd100, d); chk("zero_row100", d, 40'h0);
    read_row(9'd479, d); chk("zero_row479", d, 40'h0);

    // Scroll outside vblank, then release vblank
    w_a = 40'h11_2233_4455;
    w_b = 40'h0A_0C8_00000;
    vcount = 10'd500;
    do_shift(w_a);
    vcount = 10'd100;
    datain = w_b;
    shift  = 1'b1;
    cycle();
    shift  = 1'b0;
    repeat (8) cycle();
`ifdef BOUNDARY_VBLANK_SYNC_EN
    exp_a = w_a;
`else
    exp_a = w_b;
`endif
    read_row(9'd0, d); chk("no_tear_row0", d, exp_a);
    vcount = 10'd480;
    repeat (3) cycle();
    read_row(9'd0, d); chk("vblank_row0", d, w_b);
    readaddress = 9'd1;
    #1;
    chk("read_latency_hold", dataout, w_b);
    cycle();
    chk("vblank_row1_old", dataout, w_a);

    // 481 scrolls: head wraps all the way round
    vcount = 10'd500;
    for (int i = 0; i <= 480; i++) do_shift(40'(i));
    for (int k = 0; k < 10; k++) begin
      read_row(tbl[k].ra, d);
      chk($sformatf("wrap_tbl_ra%0d", tbl[k].ra), d, tbl[k].exp);
    end

    // Second edge two cycles after the first is dropped
    vcount = 10'd100;
    exp_b  = 40'hAB_CDEF_0123;
    datain = exp_b;
    shift  = 1'b1;
    cycle();
    shift  = 1'b0;
    cycle();
    datain = 40'hFF_FFFF_FFFF;
    shift  = 1'b1;
    cycle();
    shift  = 1'b0;
    vcount = 10'd500;
    repeat (4) cycle();
    chk("overrun_set", shift_overrun, 1'b1);
    read_row(9'd0, d); chk("overrun_row0_first", d, exp_b);
    read_row(9'd1, d); chk("overrun_row1", d, 40'd480);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("overrun_kept_on_clear", shift_overrun, 1'b1);
    count_busy("busy_len_after_clear");

    // Clear while a request waits: request discarded, full fill again
    vcount = 10'd100;
    datain = 40'h55_5555_5555;
    shift  = 1'b1;
    cycle();
    shift  = 1'b0;
    clear  = 1'b1;
    cycle();
    clear  = 1'b0;
    count_busy("busy_len_clear_mid_pend");
    vcount = 10'd500;
    repeat (5) cycle();
    read_row(9'd0, d); chk("discarded_row0", d, 40'h0);
    chk("overrun_sticky", shift_overrun, 1'b1);

    // Scroll requested during the zero fill is applied afterwards
    do_reset();
    chk("overrun_cleared_by_reset", shift_overrun, 1'b0);
    vcount = 10'd100;
    repeat (10) cycle();
    exp_b  = 40'h3C_1234_5678;
    datain = exp_b;
    shift  = 1'b1;
    cycle();
    shift  = 1'b0;
    begin
      int n;
      n = 0;
      while (busy === 1'b1 && n < 1000) begin n++; cycle(); end
      chk("busy_falls_after_held", n < 1000, 1'b1);
    end
    repeat (5) cycle();
`ifdef BOUNDARY_VBLANK_SYNC_EN
    exp_a = 40'h0;
`else
    exp_a = exp_b;
`endif
    read_row(9'd0, d); chk("held_before_vblank", d, exp_a);
    vcount = 10'd480;
    repeat (3) cycle();
    read_row(9'd0, d); chk("held_row0", d, exp_b);
    read_row(9'd1, d); chk("held_row1", d, 40'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 3) == 0) shift = ~shift;
        clear       = ($urandom_range(0, 999) == 0);
        datain      = {8'($urandom), 32'($urandom)};
        vcount      = ($urandom_range(0, 2) == 0) ? 10'($urandom_range(480, 1023))
                                                  : 10'($urandom_range(0, 479));
        readaddress = 9'($urandom_range(0, 511));
        cycle();
      end
    end
    clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
